// File: rtl/synth_pkg.sv
// Shared constants for the note-clock bank: key count, note index width,
// allocator FSM encoding and note index names (diatonic E2..E4).
package synth_pkg;

  localparam int unsigned NUM_NOTES = 15;
  localparam int unsigned NOTE_W    = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRel   = 2'd1,
    StAlloc = 2'd2
  } alloc_state_e;

  localparam logic [NOTE_W-1:0] NoteE2 = 4'd0;
  localparam logic [NOTE_W-1:0] NoteF2 = 4'd1;
  localparam logic [NOTE_W-1:0] NoteG2 = 4'd2;
  localparam logic [NOTE_W-1:0] NoteA2 = 4'd3;
  localparam logic [NOTE_W-1:0] NoteB2 = 4'd4;
  localparam logic [NOTE_W-1:0] NoteC3 = 4'd5;
  localparam logic [NOTE_W-1:0] NoteD3 = 4'd6;
  localparam logic [NOTE_W-1:0] NoteE3 = 4'd7;
  localparam logic [NOTE_W-1:0] NoteF3 = 4'd8;
  localparam logic [NOTE_W-1:0] NoteG3 = 4'd9;
  localparam logic [NOTE_W-1:0] NoteA3 = 4'd10;
  localparam logic [NOTE_W-1:0] NoteB3 = 4'd11;
  localparam logic [NOTE_W-1:0] NoteC4 = 4'd12;
  localparam logic [NOTE_W-1:0] NoteD4 = 4'd13;
  localparam logic [NOTE_W-1:0] NoteE4 = 4'd14;

endpackage

// File: rtl/voice_tick_gen.sv
// One voice slot: holds active/note, selects its note clock, emits rising-edge
// ticks and the (re)assignment start pulse, and keeps a saturating age.
module voice_tick_gen #(
  parameter int unsigned NUM_NOTES = 15,
  parameter int unsigned NOTE_W    = 4,
  parameter int unsigned AGE_W     = 8
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_NOTES-1:0] clock_array,
  input  logic                 assign_en,
  input  logic [NOTE_W-1:0]    assign_note,
  input  logic                 release_en,
  output logic                 active,
  output logic [NOTE_W-1:0]    note,
  output logic                 tick,
  output logic                 start,
  output logic [AGE_W-1:0]     age
);

  logic              active_q;
  logic [NOTE_W-1:0] note_q;
  logic              hist_q;
  logic              start_q;
  logic [AGE_W-1:0]  age_q;
  logic              clk_sel;

  assign clk_sel = clock_array[note_q];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      note_q   <= '0;
      hist_q   <= 1'b0;
      start_q  <= 1'b0;
      age_q    <= '0;
    end else if (!enable) begin
      active_q <= 1'b0;
      note_q   <= '0;
      hist_q   <= 1'b0;
      start_q  <= 1'b0;
      age_q    <= '0;
    end else begin
      start_q <= assign_en;
      if (assign_en) begin
        active_q <= 1'b1;
        note_q   <= assign_note;
        age_q    <= '0;
        // Preload history so a clock already high does not tick on assignment.
        hist_q   <= clock_array[assign_note];
      end else if (release_en) begin
        active_q <= 1'b0;
        note_q   <= '0;
        age_q    <= '0;
        hist_q   <= 1'b0;
      end else begin
        hist_q <= clk_sel;
        if (active_q && (age_q != '1)) begin
          age_q <= age_q + 1'b1;
        end
      end
    end
  end

  assign active = active_q;
  assign note   = note_q;
  assign start  = start_q;
  assign age    = age_q;
  assign tick   = enable & active_q & clk_sel & ~hist_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: key edge detection, pending press/release queues and
// a one-event-per-visit FSM. Define VOICE_STEAL_EN to steal the oldest slot when full.
module voice_allocator #(
  parameter int unsigned VOICES    = 4,
  parameter int unsigned NUM_NOTES = synth_pkg::NUM_NOTES,
  parameter int unsigned NOTE_W    = synth_pkg::NOTE_W,
  parameter int unsigned AGE_W     = 8
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_NOTES-1:0]     key_in,
  input  logic [NUM_NOTES-1:0]     CLOCK_ARRAY,
  output logic [VOICES-1:0]        voice_active,
  output logic [VOICES*NOTE_W-1:0] voice_note,
  output logic [VOICES-1:0]        voice_tick,
  output logic [VOICES-1:0]        voice_start,
  output logic                     drop_pulse
);

  import synth_pkg::*;

  alloc_state_e state_q, state_d;

  logic [NUM_NOTES-1:0] key_q;
  logic [NUM_NOTES-1:0] press_edge, rel_edge;
  logic [NUM_NOTES-1:0] pend_p_q, pend_p_d;
  logic [NUM_NOTES-1:0] pend_r_q, pend_r_d;
  logic [NOTE_W-1:0]    pend_p_idx, pend_r_idx;

  logic [NOTE_W-1:0]    note_arr [VOICES];
  logic [AGE_W-1:0]     age_arr  [VOICES];
  logic [VOICES-1:0]    free_sel, oldest_sel, assign_vec, release_vec;
  logic                 free_found;
  logic [AGE_W-1:0]     best_age;
  int                   best_v;

  logic                 do_rel, do_alloc, drop_d, drop_q;

  assign press_edge = key_in & ~key_q;
  assign rel_edge   = ~key_in & key_q;

  // Lowest-index priority encoders over the pending vectors.
  always_comb begin
    pend_p_idx = '0;
    pend_r_idx = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (pend_p_q[i]) pend_p_idx = NOTE_W'(i);
      if (pend_r_q[i]) pend_r_idx = NOTE_W'(i);
    end
  end

  // Lowest free slot and oldest slot (max age, ties to lowest index).
  always_comb begin
    free_sel   = '0;
    free_found = 1'b0;
    best_age   = '0;
    best_v     = 0;
    oldest_sel = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (!voice_active[v] && !free_found) begin
        free_sel[v] = 1'b1;
        free_found  = 1'b1;
      end
      if (age_arr[v] > best_age) begin
        best_age = age_arr[v];
        best_v   = v;
      end
    end
    for (int v = 0; v < VOICES; v++) begin
      oldest_sel[v] = (v == best_v);
    end
  end

  // FSM: state register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else if (!enable) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (|pend_r_q) begin
          state_d = StRel;
        end else if (|pend_p_q) begin
          state_d = StAlloc;
        end
      end
      StRel:   state_d = StIdle;
      StAlloc: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. Pending bits can vanish between IDLE and service, hence the guards.
  always_comb begin
    do_rel      = enable && (state_q == StRel) && (|pend_r_q);
    do_alloc    = enable && (state_q == StAlloc) && (|pend_p_q);
    assign_vec  = '0;
    release_vec = '0;
    drop_d      = 1'b0;
    if (do_alloc) begin
`ifdef VOICE_STEAL_EN
      assign_vec = free_found ? free_sel : oldest_sel;
`else
      assign_vec = free_found ? free_sel : '0;
      drop_d     = ~free_found;
`endif
    end
    for (int v = 0; v < VOICES; v++) begin
      release_vec[v] = do_rel && voice_active[v] && (note_arr[v] == pend_r_idx);
    end
  end

`ifndef VOICE_STEAL_EN
  logic unused_oldest;
  assign unused_oldest = ^oldest_sel;
`endif

  // Service clears first, then new edges apply so a same-cycle edge wins.
  always_comb begin
    pend_p_d = pend_p_q;
    pend_r_d = pend_r_q;
    if (do_alloc) pend_p_d[pend_p_idx] = 1'b0;
    if (do_rel)   pend_r_d[pend_r_idx] = 1'b0;
    pend_p_d = pend_p_d | press_edge;
    pend_r_d = pend_r_d | (rel_edge & ~pend_p_d);
    pend_p_d = pend_p_d & ~rel_edge;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      pend_p_q <= '0;
      pend_r_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      key_q <= key_in;
      if (!enable) begin
        pend_p_q <= '0;
        pend_r_q <= '0;
        drop_q   <= 1'b0;
      end else begin
        pend_p_q <= pend_p_d;
        pend_r_q <= pend_r_d;
        drop_q   <= drop_d;
      end
    end
  end

  assign drop_pulse = drop_q;

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    voice_tick_gen #(
      .NUM_NOTES (NUM_NOTES),
      .NOTE_W    (NOTE_W),
      .AGE_W     (AGE_W)
    ) u_voice (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .enable      (enable),
      .clock_array (CLOCK_ARRAY),
      .assign_en   (assign_vec[v]),
      .assign_note (pend_p_idx),
      .release_en  (release_vec[v]),
      .active      (voice_active[v]),
      .note        (note_arr[v]),
      .tick        (voice_tick[v]),
      .start       (voice_start[v]),
      .age         (age_arr[v])
    );
    assign voice_note[v*NOTE_W +: NOTE_W] = note_arr[v];
  end

endmodule
